ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 168 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 frame receiver with held-level decode of arrow/W/S/Space keys
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       PS2_CLK_in,
  input  logic       PS2_DAT_in,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       key_up,
  output logic       key_down,
  output logic       key_w,
  output logic       key_s,
  output logic       key_space
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_W     = 2;
  localparam int K_S     = 3;
  localparam int K_SPACE = 4;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [2:0]      clk_sync_q;
  logic [1:0]      dat_sync_q;
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      scan_q, scan_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            brk_q, brk_d;
  logic            ext_q, ext_d;
  logic [4:0]      keys_q, keys_d;
  logic            fall;
  logic            din;
  logic            accept;

  // Stage [2] is the previous synchronized clock value for edge detection.
  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign din  = dat_sync_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    wd_d      = wd_q;
    scan_d    = scan_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    brk_d     = brk_q;
    ext_d     = ext_q;
    keys_d    = keys_q;
    accept    = 1'b0;

    if (state_q == IDLE || fall) wd_d = '0;
    else                         wd_d = wd_q + WD_W'(1);

    case (state_q)
      IDLE: begin
        if (fall && !din) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = din;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (din && (^{shift_q, par_q})) accept = 1'b1;
          else                            err_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !fall && wd_q == WD_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
      wd_d    = '0;
    end

    if (accept) begin
      scan_d  = shift_q;
      valid_d = 1'b1;
      if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        // Prefix flags qualify exactly one following byte.
        case ({ext_q, shift_q})
          9'h175:  keys_d[K_UP]    = ~brk_q;
          9'h172:  keys_d[K_DOWN]  = ~brk_q;
          9'h01D:  keys_d[K_W]     = ~brk_q;
          9'h01B:  keys_d[K_S]     = ~brk_q;
          9'h029:  keys_d[K_SPACE] = ~brk_q;
          default: ;
        endcase
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      wd_q       <= '0;
      scan_q     <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      keys_q     <= 5'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], PS2_CLK_in};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT_in};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      scan_q     <= scan_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      keys_q     <= keys_d;
    end
  end

  assign scan_code  = scan_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;
  assign key_up     = keys_q[K_UP];
  assign key_down   = keys_q[K_DOWN];
  assign key_w      = keys_q[K_W];
  assign key_s      = keys_q[K_S];
  assign key_space  = keys_q[K_SPACE];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed PS/2 frame bench with scan-code scoreboard
module tb_ps2_key_decoder;

  localparam int TO = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       PS2_CLK_in = 1'b1;
  logic       PS2_DAT_in = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, frame_err;
  logic       key_up, key_down, key_w, key_s, key_space;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int err_exp  = 0;
  logic [7:0] exp_q[$];

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .PS2_CLK_in(PS2_CLK_in), .PS2_DAT_in(PS2_DAT_in),
    .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err),
    .key_up(key_up), .key_down(key_down), .key_w(key_w), .key_s(key_s),
    .key_space(key_space)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the next queued expectation.
  always @(negedge clock) begin
    if (code_valid) begin
      n_valid++;
      if (exp_q.size() == 0) chk("unexpected_code_valid", 32'd1, 32'd0);
      else                   chk("scan_code_at_valid", {24'd0, scan_code}, {24'd0, exp_q.pop_front()});
    end
    if (frame_err) n_err++;
  end

  task automatic ps2_bit(input logic b);
    PS2_DAT_in = b;
    repeat (8) @(negedge clock);
    PS2_CLK_in = 1'b0;
    repeat (8) @(negedge clock);
    PS2_CLK_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
    if (!par_flip && stop_bit) exp_q.push_back(b);
    else                       err_exp++;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ par_flip);
    ps2_bit(stop_bit);
    PS2_DAT_in = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(2);
    chk("rst_scan_code", {24'd0, scan_code}, 32'h00);
    chk("rst_code_valid", {31'd0, code_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_keys", {27'd0, key_up, key_down, key_w, key_s, key_space}, 32'd0);

    good(8'h1D);
    chk("w_make_key_w", {31'd0, key_w}, 32'd1);
    chk("w_make_scan", {24'd0, scan_code}, 32'h1D);
    chk("w_make_valid_cnt", n_valid, 1);
    good(8'hF0);
    good(8'h1D);
    chk("w_break_key_w", {31'd0, key_w}, 32'd0);
    chk("w_valid_cnt", n_valid, 3);

    good(8'hE0);
    chk("up_after_e0", {31'd0, key_up}, 32'd0);
    good(8'h75);
    chk("up_make", {31'd0, key_up}, 32'd1);
    good(8'hE0);
    good(8'hF0);
    chk("up_held_before_code", {31'd0, key_up}, 32'd1);
    good(8'h75);
    chk("up_break", {31'd0, key_up}, 32'd0);
    good(8'h75);
    chk("bare_75_no_up", {31'd0, key_up}, 32'd0);

    send_frame(8'h29, 1'b1, 1'b1);
    chk("bad_par_err_cnt", n_err, err_exp);
    chk("bad_par_space", {31'd0, key_space}, 32'd0);
    chk("bad_par_scan_kept", {24'd0, scan_code}, 32'h75);
    good(8'h29);
    chk("space_make", {31'd0, key_space}, 32'd1);
    good(8'h29);
    chk("space_typematic", {31'd0, key_space}, 32'd1);

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    err_exp++;
    wait_cycles(TO + 50);
    chk("timeout_err_cnt", n_err, err_exp);
    good(8'h1B);
    chk("s_make_after_timeout", {31'd0, key_s}, 32'd1);

    send_frame(8'h1D, 1'b0, 1'b0);
    chk("bad_stop_err_cnt", n_err, err_exp);
    chk("bad_stop_key_w", {31'd0, key_w}, 32'd0);

    good(8'h1D);
    chk("w_held", {31'd0, key_w}, 32'd1);
    chk("s_held", {31'd0, key_s}, 32'd1);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    PS2_DAT_in = 1'b1;
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    wait_cycles(TO + 50);
    chk("midrst_keys", {26'd0, code_valid, key_up, key_down, key_w, key_s, key_space}, 32'd0);
    chk("midrst_scan", {24'd0, scan_code}, 32'h00);
    chk("midrst_no_err", n_err, err_exp);
    good(8'hF0);
    good(8'h1D);
    chk("midrst_w_stays_0", {31'd0, key_w}, 32'd0);

    good(8'hE0);
    good(8'h1D);
    chk("ext_1d_ignored", {31'd0, key_w}, 32'd0);
    good(8'hE0);
    good(8'h75);
    good(8'h1D);
    chk("combo_up", {31'd0, key_up}, 32'd1);
    chk("combo_w", {31'd0, key_w}, 32'd1);
    good(8'hF0);
    good(8'h1D);
    chk("combo_w_break", {31'd0, key_w}, 32'd0);
    chk("combo_up_kept", {31'd0, key_up}, 32'd1);
    good(8'hE0);
    good(8'h72);
    chk("down_make", {31'd0, key_down}, 32'd1);

    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_err_cnt", n_err, err_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
